// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit adder/subtractor built around a
// single 4-bit carry-lookahead adder. Operands are captured on an input
// handshake. One nibble is processed per cycle, least significant nibble
// first. The carry is held in a register between nibbles. The result is held
// behind an output handshake until the consumer takes it.

// cla: 4-bit carry-lookahead adder slice.
module cla (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic       Cout,
    output logic [3:0] S
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Per-bit generate/propagate terms and sum bits.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_bit
            assign g[gi] = A[gi] & B[gi];
            assign p[gi] = A[gi] ^ B[gi];
            assign S[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    // Each carry is written out in flat lookahead form, so there is no ripple
    // chain inside the slice.
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign Cout = c[4];

endmodule

// Top level: handshake wrapper and nibble sequencer around one cla slice.
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / 4;
    // The index needs at least one bit, even when there is only one nibble.
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             overflow_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    // The bit offset of the current nibble is idx*4. It is formed by
    // concatenation so that no multiplier is needed.
    logic [IDX_W+1:0] nib_base;
    logic [3:0]       cla_a;
    logic [3:0]       cla_b;
    logic [3:0]       cla_s;
    logic             cla_cout;

    assign nib_base = {idx_reg, 2'b00};
    assign cla_a    = a_reg[nib_base +: 4];
    assign cla_b    = b_reg[nib_base +: 4];

    cla u_cla (
        .A    (cla_a),
        .B    (cla_b),
        .Cin  (carry_reg),
        .Cout (cla_cout),
        .S    (cla_s)
    );

    // Sequencer: capture the operands, step through the nibbles, then hold the
    // result until it is taken. Every output comes straight from a register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            carry_reg     <= 1'b0;
            idx_reg       <= '0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        // Subtraction is a + ~b + 1, so the inversion and the
                        // forced carry-in are applied once, at capture time.
                        a_reg        <= a;
                        b_reg        <= sub ? ~b : b;
                        carry_reg    <= sub ? 1'b1 : cin;
                        idx_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                    end
                end

                RUN: begin
                    sum_reg[nib_base +: 4] <= cla_s;
                    carry_reg              <= cla_cout;
                    if (idx_reg == LAST_IDX) begin
                        // The top nibble's sum bit 3 is the result sign. The
                        // operand signs come from the captured (effective) b.
                        cout_reg      <= cla_cout;
                        overflow_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                         (cla_s[3] != a_reg[WIDTH-1]);
                        idx_reg       <= '0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed vectors with hand-computed results. An
// arithmetic reference model predicts every result, and a compare process
// checks the DUT against that model on every cycle that out_valid is high.
module tb_nibble_serial_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Each entry is {overflow, cout, sum}.
    logic [W+1:0] exp_q[$];

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference model. The unsigned wide sum gives sum and cout. The signed sum
    // gives overflow: overflow is set when that sum falls outside the range of
    // a W-bit signed value.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic ms);
        logic [W-1:0] beff;
        logic [W:0]   t;
        int           c0;
        int           sres;
        logic         ov;
        beff = ms ? ~mb : mb;
        c0   = ms ? 1 : int'(mc);
        t    = {1'b0, ma} + {1'b0, beff} + (W+1)'(c0);
        sres = int'($signed(ma)) + int'($signed(beff)) + c0;
        ov   = (sres > 32767) || (sres < -32768);
        return {ov, t};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Record the model's prediction on each accepted beat. A reset discards
    // any operation in flight.
    always @(posedge clk) begin
        if (!rst_n)
            exp_q.delete();
        else if (in_valid && in_ready)
            exp_q.push_back(model(a, b, cin, sub));
    end

    // Check the DUT against the model on every cycle that out_valid is high.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                check("model_sum", 32'(sum), 32'(exp_q[0][W-1:0]));
                check("model_cout", 32'(cout), 32'(exp_q[0][W]));
                check("model_overflow", 32'(overflow), 32'(exp_q[0][W+1]));
                check("in_ready_low_in_done", 32'(in_ready), 32'd0);
                if (out_ready)
                    void'(exp_q.pop_front());
            end
        end
    end

    // Run one transaction and check the output latency and the literal result.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts,
                        input logic [W-1:0] esum, input logic ecout, input logic eovf,
                        input string tag);
        int cnt;
        bit seen;
        @(posedge clk); #1;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!in_ready) check({tag, "_in_ready_timeout"}, 32'd0, 32'd1);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        // Drive the operand inputs with other values after the accept edge.
        in_valid = 1'b0; a = ~ta; b = ~tb; cin = ~tc; sub = ~ts;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 20) begin
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                cnt++;
            end
        end
        if (!seen) begin
            check({tag, "_out_valid_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_latency"}, 32'(cnt), 32'd4);
            check({tag, "_sum"}, 32'(sum), 32'(esum));
            check({tag, "_cout"}, 32'(cout), 32'(ecout));
            check({tag, "_overflow"}, 32'(overflow), 32'(eovf));
            $display("txn %s: a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d",
                     tag, ta, tb, tc, ts, sum, cout, overflow);
            if (out_ready) begin
                @(posedge clk); #1;
                check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;

        // Pin the model itself to hand-computed values.
        check("pin_model_ovf_add", 32'(model(16'h7FFF, 16'h0001, 1'b0, 1'b0)), 32'h28000);
        check("pin_model_sub_borrow", 32'(model(16'h0005, 16'h0007, 1'b0, 1'b1)), 32'h0FFFE);
        check("pin_model_sub_ovf", 32'(model(16'h8000, 16'h0001, 1'b0, 1'b1)), 32'h37FFF);

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        send(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic");
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple_b1");
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple_cin");
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_add");
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "ovf_sub");
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_cin0");
        send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_cin1");
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf");
        send(16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0, "mixed_cin");

        // Backpressure: hold the result for three cycles while sending stray
        // in_valid pulses, which must not be accepted.
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, "bp");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 16'h0F0F; b = 16'h00F0; sub = 1'b0; cin = 1'b0;
            @(posedge clk); #1;
            check("bp_out_valid_held", 32'(out_valid), 32'd1);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_sum_stable", 32'(sum), 32'h3333);
            check("bp_cout_stable", 32'(cout), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        send(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, "after_bp");

        // Reset in the middle of RUN: the partial result must be discarded.
        @(posedge clk); #1;
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, "after_rst");

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle WIDTH-bit adder/subtractor built on one instance of the team's 4-bit carry-lookahead adder `cla`, with ports A, B, Cin, Cout and S.
- It sits directly upstream of the `cla`: it captures wide operands and feeds the `cla` one nibble per cycle, LSB nibble first.
- It registers the `cla` carry-out between nibbles and assembles the sum.
- Valid/ready handshakes on both sides let it slot into datapath pipelines.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4. NIBBLES = WIDTH/4 is derived, not overridable.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (ignored when sub=1)
sub  input  1  1: compute a - b
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry-out of the MSB nibble
overflow  output  1  two's-complement signed overflow

Behaviour:
Clock and reset
- Single clock, clk. rst_n is synchronous active-low, sampled on the rising clk edge.
- Reset values: state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; overflow=0; nibble index=0; carry register=0; operand registers=0.

Operand capture
- On accept, a_r<=a and b_r<= (sub ? ~b : b).
- Carry register <= (sub ? 1 : cin).
- a, b, cin and sub need not stay stable after the accept edge.

FSM: IDLE -> RUN -> DONE -> IDLE
- IDLE
  - in_ready=1, out_valid=0.
  - An accept is in_valid & in_ready on a clk edge; it captures operands, sets idx<=0 and moves to RUN.
- RUN
  - in_ready=0, out_valid=0.
  - Each cycle the `cla` is driven with A=a_r[4*idx+:4], B=b_r[4*idx+:4], Cin=carry register.
  - On the edge: sum[4*idx+:4]<=S, carry register<=Cout, idx<=idx+1.
  - When idx==NIBBLES-1 on that edge:
    - cout<=Cout;
    - overflow<=(a_r[WIDTH-1]==b_r[WIDTH-1]) & (S[3]!=a_r[WIDTH-1]);
    - move to DONE.
- DONE
  - out_valid=1, in_ready=0.
  - sum, cout and overflow are held stable while out_valid & !out_ready.
  - On out_valid & out_ready: go to IDLE; out_valid drops next cycle.
  - sum, cout and overflow keep their last values in IDLE; they are only meaningful while out_valid=1.

Latency and throughput
- With the accept on edge 0, out_valid is seen high after edge NIBBLES (4 cycles for WIDTH=16).
- No overlap between transactions: in_ready is high only in IDLE.
- Best-case throughput is one result per NIBBLES+2 cycles.

Arithmetic
- sum = (a + b_eff + c0) mod 2^WIDTH, where b_eff = sub ? ~b : b and c0 = sub ? 1 : cin.
- cout is the true carry out of bit WIDTH-1; for subtraction cout=1 means no borrow.
- sub=1 always forces carry-in to 1, whatever cin is.

Boundary conditions
- WIDTH=4: RUN lasts exactly one cycle.
- idx wraps only via the RUN->DONE transition; it is reset to 0 on each accept.
- in_valid held high during RUN or DONE is ignored (not accepted) until IDLE.
- rst_n low in any state, including mid-RUN or DONE with out_ready low: next edge returns every register to its reset value; the partial result is discarded and never presented.
- If out_ready is already high on the first DONE cycle, the result is consumed in that cycle.

Test Plan:
1. WIDTH=16, a=0x1234, b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, overflow=0; out_valid first high exactly 4 edges after accept.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0 (carry ripples through all 4 nibbles via the carry register). Then a=0xFFFF, b=0x0000, cin=1 -> same result.
3. a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, overflow=1. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, overflow=1.
4. a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0 (borrow), overflow=0. Confirm cin=1 gives the identical result.
5. Backpressure: out_ready low for 3 cycles in DONE -> out_valid stays 1, sum/cout/overflow stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> IDLE the next cycle, then a new accept proceeds normally.
6. Reset mid-operation: accept a=0xAAAA, b=0x5555, pull rst_n low after 2 RUN cycles -> next edge gives in_ready=1, out_valid=0, sum=0, cout=0, overflow=0. A follow-up transaction 0x0001+0x0001 -> sum=0x0002, with no residue from the discarded operation.
